// File: rtl/rf_wb_pkg.sv
// Shared sizes and the writeback request record for the per-warp register block.
package rf_wb_pkg;

    localparam int NUM_LANES = 16;
    localparam int DATA_W    = 64;
    localparam int NUM_REGS  = 16;
    localparam int NUM_WARPS = 16;
    localparam int REG_AW    = $clog2(NUM_REGS);
    localparam int WARP_W    = $clog2(NUM_WARPS);

    typedef struct packed {
        logic [WARP_W-1:0]           warp;
        logic [REG_AW-1:0]           addr;
        logic [NUM_LANES-1:0]        mask;
        logic [NUM_LANES*DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester bus, read-side warp handshake and register-block write port.
interface rf_wb_arbiter_if
    import rf_wb_pkg::*;
#(
    parameter int NUM_REQ = 3
);

    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ*WARP_W-1:0]           req_warp;
    logic [NUM_REQ*REG_AW-1:0]           req_addr;
    logic [NUM_REQ*NUM_LANES-1:0]        req_mask;
    logic [NUM_REQ*NUM_LANES*DATA_W-1:0] req_data;
    logic                                rd_active;
    logic [WARP_W-1:0]                   rd_warp;
    logic                                rd_stall;
    logic [NUM_LANES-1:0]                rf_write_en;
    logic [REG_AW-1:0]                   rf_waddr;
    logic [NUM_LANES*DATA_W-1:0]         rf_wdata;
    logic [WARP_W-1:0]                   rf_warp_selector;

    modport master (
        output req_valid, req_warp, req_addr, req_mask, req_data, rd_active, rd_warp,
        input  req_ready, rd_stall, rf_write_en, rf_waddr, rf_wdata, rf_warp_selector
    );

    modport slave (
        input  req_valid, req_warp, req_addr, req_mask, req_data, rd_active, rd_warp,
        output req_ready, rd_stall, rf_write_en, rf_waddr, rf_wdata, rf_warp_selector
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: first request at or after the pointer, wrapping upward.
// Latency: grant is combinational from req; pointer moves on the accepting edge.
// Backpressure: pointer holds unless accept is high, so an unaccepted grant is re-offered.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0] N_EXT = (PW+1)'(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Scan offsets high to low so the smallest offset from the pointer is the last writer.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        sum   = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= N_EXT) begin
                sum = sum - N_EXT;
            end
            idx = sum[PW-1:0];
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                ptr_d      = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter sharing the register block's single write port; owns warp_selector.
// Latency: grant in cycle N, write presented to the register block during N+1 (commit at end of N+1).
// Backpressure: req_ready is the one-hot grant; warp mismatch blocks, starvation forces rd_stall.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int STARVE_LIMIT = 8
) (
    input logic              clk,
    input logic              rst_n,
    rf_wb_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    wb_req_t            req [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic               any_grant;

    wb_req_t            stage_d;
    wb_req_t            stage_q;
    logic               stage_vld_q;
    logic [CNT_W-1:0]   starve_q;
    logic               stall_q;

    // Eligibility is gated by rst_n so req_ready stays low throughout reset.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req[i].warp = bus.req_warp[i*WARP_W +: WARP_W];
        assign req[i].addr = bus.req_addr[i*REG_AW +: REG_AW];
        assign req[i].mask = bus.req_mask[i*NUM_LANES +: NUM_LANES];
        assign req[i].data = bus.req_data[i*NUM_LANES*DATA_W +: NUM_LANES*DATA_W];
        assign elig[i]     = rst_n & bus.req_valid[i]
                           & (~bus.rd_active | (bus.rd_warp == req[i].warp) | stall_q);
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (elig),
        .accept (any_grant),
        .grant  (grant)
    );

    assign any_grant     = |grant;
    assign bus.req_ready = grant;

    always_comb begin
        stage_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                stage_d = req[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            stage_vld_q <= any_grant;
        end
    end

    // Counter only ticks while something waits and nothing can go; any grant resets it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            if (any_grant) begin
                starve_q <= '0;
            end else if ((|bus.req_valid) && !(|elig) && !stall_q
                         && (starve_q != CNT_W'(STARVE_LIMIT))) begin
                starve_q <= starve_q + 1'b1;
            end

            if (stall_q && any_grant) begin
                stall_q <= 1'b0;
            end else if (starve_q == CNT_W'(STARVE_LIMIT)) begin
                stall_q <= 1'b1;
            end
        end
    end

    // A staged write is suppressed while reset is asserted so it can never commit.
    assign bus.rf_write_en      = (stage_vld_q && rst_n) ? stage_q.mask : '0;
    assign bus.rf_waddr         = stage_q.addr;
    assign bus.rf_wdata         = stage_q.data;
    assign bus.rf_warp_selector = stage_vld_q ? stage_q.warp : bus.rd_warp;
    assign bus.rd_stall         = stall_q;

endmodule
